// File: rtl/sampq_pkg.sv
// Shared constants, FSM state type and CRC parameters for the sample stream reader.
// The CRC states exist only when SAMP_STREAM_READER_CRC_EN is defined.
package sampq_pkg;

    localparam logic [7:0]  SYNC_BYTE    = 8'h7E;
    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam int unsigned SAMPLE_BYTES = 9;

`ifdef SAMP_STREAM_READER_CRC_EN
    typedef enum logic [2:0] {
        IDLE, SYNC, SEQ, LEN, PAYLOAD, CRC_LO, CRC_HI
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE, SYNC, SEQ, LEN, PAYLOAD
    } state_e;
`endif

endpackage

// File: rtl/crc16_ccitt_byte.sv
// One-byte CRC-16/CCITT step (poly 0x1021, MSB-first), purely combinational.
// Instantiated by samp_stream_reader only when SAMP_STREAM_READER_CRC_EN is defined.
module crc16_ccitt_byte
    import sampq_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {data_in, 8'h00};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/samp_stream_reader.sv
// Packetises bytes from the sample queue as 7E, SEQ, LEN, payload [, CRC_LO, CRC_HI].
// Optional CRC trailer is compiled in with SAMP_STREAM_READER_CRC_EN.
module samp_stream_reader
    import sampq_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 252
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  samp_stream_data,
    input  logic [9:0]  samp_stream_count,
    input  logic        samp_stream_avail,
    output logic        samp_stream_pull,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        enable,
    output logic [15:0] pkt_count
);

    if (((MAX_PAYLOAD % SAMPLE_BYTES) != 0) || (MAX_PAYLOAD > 255)) begin : g_bad_cfg
        $error("MAX_PAYLOAD must be a multiple of SAMPLE_BYTES and <= 255");
    end

    localparam logic [9:0] MAX_LEN = 10'(MAX_PAYLOAD);

    state_e      state_q, state_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  rem_q, rem_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic [7:0]  len_new;
    logic        xfer;
    logic        trigger;
    logic        done;

    assign tx_valid  = (state_q != IDLE);
    assign xfer      = tx_valid && tx_ready;
    assign trigger   = enable && samp_stream_avail && (samp_stream_count != '0);
    assign len_new   = (samp_stream_count > MAX_LEN) ? MAX_LEN[7:0] : samp_stream_count[7:0];
    assign pkt_count = pkt_count_q;

`ifdef SAMP_STREAM_READER_CRC_EN
    logic [15:0] crc_q, crc_d, crc_next;

    crc16_ccitt_byte u_crc (
        .crc_in  (crc_q),
        .data_in (tx_data),
        .crc_out (crc_next)
    );
`endif

    always_comb begin
        tx_data          = '0;
        samp_stream_pull = 1'b0;
        case (state_q)
            SYNC:    tx_data = SYNC_BYTE;
            SEQ:     tx_data = seq_q;
            LEN:     tx_data = len_q;
            PAYLOAD: begin
                tx_data          = samp_stream_data;
                samp_stream_pull = tx_ready;
            end
`ifdef SAMP_STREAM_READER_CRC_EN
            CRC_LO:  tx_data = crc_q[7:0];
            CRC_HI:  tx_data = crc_q[15:8];
`endif
            default: tx_data = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        len_d       = len_q;
        rem_d       = rem_q;
        pkt_count_d = pkt_count_q;
        done        = 1'b0;
`ifdef SAMP_STREAM_READER_CRC_EN
        crc_d       = crc_q;
`endif
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = SYNC;
                    len_d   = len_new;
                    rem_d   = len_new;
`ifdef SAMP_STREAM_READER_CRC_EN
                    crc_d   = CRC_INIT;
`endif
                end
            end
            SYNC: if (xfer) state_d = SEQ;
            SEQ: if (xfer) begin
                state_d = LEN;
`ifdef SAMP_STREAM_READER_CRC_EN
                crc_d   = crc_next;
`endif
            end
            LEN: if (xfer) begin
                state_d = PAYLOAD;
`ifdef SAMP_STREAM_READER_CRC_EN
                crc_d   = crc_next;
`endif
            end
            PAYLOAD: if (xfer) begin
                rem_d = rem_q - 8'd1;
`ifdef SAMP_STREAM_READER_CRC_EN
                crc_d = crc_next;
                if (rem_q == 8'd1) state_d = CRC_LO;
`else
                if (rem_q == 8'd1) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
`endif
            end
`ifdef SAMP_STREAM_READER_CRC_EN
            CRC_LO: if (xfer) state_d = CRC_HI;
            CRC_HI: if (xfer) begin
                state_d = IDLE;
                done    = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
        // SEQ and pkt_count advance together on the final byte of a packet
        if (done) begin
            seq_d       = seq_q + 8'd1;
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            pkt_count_q <= '0;
`ifdef SAMP_STREAM_READER_CRC_EN
            crc_q       <= CRC_INIT;
`endif
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            pkt_count_q <= pkt_count_d;
`ifdef SAMP_STREAM_READER_CRC_EN
            crc_q       <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_samp_stream_reader.sv
// Scoreboard bench for samp_stream_reader: stimulus queues expected packet bytes,
// a negedge monitor compares every presented byte, pull and inter-packet gap.
module tb_samp_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  samp_stream_data;
    logic [9:0]  samp_stream_count = '0;
    logic        samp_stream_avail = 1'b0;
    logic        samp_stream_pull;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        enable = 1'b1;
    logic [15:0] pkt_count;

    samp_stream_reader #(.MAX_PAYLOAD(252)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .samp_stream_data  (samp_stream_data),
        .samp_stream_count (samp_stream_count),
        .samp_stream_avail (samp_stream_avail),
        .samp_stream_pull  (samp_stream_pull),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .enable            (enable),
        .pkt_count         (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       pay;
        logic       last;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int pulls = 0;
    int idle_run = 0;
    bit gap_chk = 1'b0;
    bit seen_last = 1'b0;
    bit ready_mode = 1'b0;

    // bench models
    int         exp_ptr = 0;
    logic [7:0] seq_m = '0;
    int         pkt_m = 0;

    // upstream sample queue: byte value is read pointer + 1
    logic [15:0] rd_ptr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ptr <= '0;
        else if (samp_stream_pull) rd_ptr <= rd_ptr + 16'd1;
    end
    assign samp_stream_data = rd_ptr[7:0] + 8'd1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    // ready pattern 1,0,0,1 when enabled
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = ready_mode ? pat[ph] : 1'b1;
            ph = (ph + 1) % 4;
        end
    end

    // monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (samp_stream_pull) pulls++;
            if (tx_valid) begin
                if (gap_chk && seen_last && idle_run > 0) begin
                    chk("idle_gap", idle_run, 1);
                    seen_last = 1'b0;
                end
                idle_run = 0;
                if (q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("tx_data", {24'd0, tx_data}, {24'd0, q[0].data});
                    chk("pull", {31'd0, samp_stream_pull}, q[0].pay ? {31'd0, tx_ready} : 32'd0);
                    if (tx_ready) begin
                        if (q[0].last) seen_last = 1'b1;
                        void'(q.pop_front());
                    end
                end
            end else begin
                idle_run++;
                if (samp_stream_pull) chk("idle_pull", 1, 0);
            end
        end
    end

    task automatic push_packet(input int len);
        logic [15:0] crc;
        exp_t e;
        crc = 16'hFFFF;
        e = '{data: 8'h7E, pay: 1'b0, last: 1'b0};
        q.push_back(e);
        e.data = seq_m;  q.push_back(e); crc = crc_upd(crc, seq_m);
        e.data = 8'(len); q.push_back(e); crc = crc_upd(crc, 8'(len));
        for (int i = 0; i < len; i++) begin
            e.data = 8'(exp_ptr + 1);
            e.pay = 1'b1;
            e.last = 1'b0;
            exp_ptr++;
            crc = crc_upd(crc, e.data);
            q.push_back(e);
        end
`ifdef SAMP_STREAM_READER_CRC_EN
        e = '{data: crc[7:0], pay: 1'b0, last: 1'b0};
        q.push_back(e);
        e.data = crc[15:8];
        q.push_back(e);
`endif
        q[q.size() - 1].last = 1'b1;
        seq_m = seq_m + 8'd1;
        pkt_m++;
    endtask

    task automatic wait_pkts(input int target);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            #1;
            if (pkt_count == 16'(target)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("pkt_timeout", {16'd0, pkt_count}, target);
    endtask

    task automatic run_packets(input int n, input int cnt, input bit lat);
        int len;
        int p0;
        len = (cnt > 252) ? 252 : cnt;
        for (int p = 0; p < n; p++) push_packet(len);
        p0 = pulls;
        samp_stream_count = 10'(cnt);
        samp_stream_avail = 1'b1;
        if (lat) begin
            @(negedge clk);
            chk("lat_idle_valid", {31'd0, tx_valid}, 0);
            @(posedge clk);
            #1;
            chk("lat_sync_valid", {31'd0, tx_valid}, 1);
            chk("lat_sync_data", {24'd0, tx_data}, 32'h7E);
        end
        wait_pkts(pkt_m);
        samp_stream_avail = 1'b0;
        samp_stream_count = '0;
        chk("pkt_count", {16'd0, pkt_count}, 32'(pkt_m & 16'hFFFF));
        chk("pulls", pulls - p0, n * len);
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        exp_ptr = 0;
        seq_m = '0;
        pkt_m = 0;
        samp_stream_avail = 1'b0;
        samp_stream_count = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        #1;
        chk("rst_valid", {31'd0, tx_valid}, 0);
        chk("rst_pull", {31'd0, samp_stream_pull}, 0);
        chk("rst_data", {24'd0, tx_data}, 0);
        chk("rst_pkt_count", {16'd0, pkt_count}, 0);
        do_reset();

        // 18-byte packet, first-byte latency
        run_packets(1, 18, 1'b1);

        // MAX_PAYLOAD clamp with one idle cycle between packets
        gap_chk = 1'b1;
        seen_last = 1'b0;
        run_packets(3, 864, 1'b0);
        gap_chk = 1'b0;

        // tx_ready stalls
        ready_mode = 1'b1;
        run_packets(1, 9, 1'b0);
        ready_mode = 1'b0;
        @(posedge clk);
        #1;

        // enable dropped after LEN byte
        push_packet(9);
        samp_stream_count = 10'd9;
        samp_stream_avail = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        wait_pkts(pkt_m);
        chk("en_pkt_count", {16'd0, pkt_count}, 32'(pkt_m));
        repeat (20) @(posedge clk);
        #1;
        chk("en_blocked_valid", {31'd0, tx_valid}, 0);
        samp_stream_avail = 1'b0;
        samp_stream_count = '0;
        enable = 1'b1;
        @(posedge clk);
        #1;

        // reset mid-payload
        push_packet(18);
        p0 = pulls;
        samp_stream_count = 10'd18;
        samp_stream_avail = 1'b1;
        for (int c = 0; c < 200 && (pulls - p0) < 3; c++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, tx_valid}, 0);
        chk("arst_pull", {31'd0, samp_stream_pull}, 0);
        chk("arst_data", {24'd0, tx_data}, 0);
        q.delete();
        exp_ptr = 0;
        seq_m = '0;
        pkt_m = 0;
        samp_stream_avail = 1'b0;
        samp_stream_count = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("arst_pkt_count", {16'd0, pkt_count}, 0);
        @(posedge clk);
        #1;
        run_packets(1, 9, 1'b0);

        // SEQ wrap over 256 packets, then one more with SEQ 00
        do_reset();
        run_packets(256, 9, 1'b0);
        chk("wrap_pkt_count", {16'd0, pkt_count}, 256);
        run_packets(1, 9, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("final_queue", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/samp_stream_reader.md
SAMP_STREAM_READER -- requirements
Module: samp_stream_reader

Interface
REQ-001 Parameter MAX_PAYLOAD, default 252; maximum payload bytes per packet; SHALL be a multiple of 9 and <= 255.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 samp_stream_data  input  8  current sample byte from the sample queue.
REQ-005 samp_stream_count  input  10  bytes guaranteed pullable; always a multiple of 9.
REQ-006 samp_stream_avail  input  1  sample queue has data worth sending.
REQ-007 samp_stream_pull  output  1  consume one byte this cycle.
REQ-008 tx_data  output  8  packet byte toward host transport.
REQ-009 tx_valid  output  1  tx_data valid.
REQ-010 tx_ready  input  1  transport accepts byte this cycle.
REQ-011 enable  input  1  permit new packets.
REQ-012 pkt_count  output  16  packets completed since reset.

Function
REQ-013 Packet format SHALL be: 0x7E, SEQ, LEN, LEN payload bytes, then CRC_LO, CRC_HI when CRC is compiled in.
REQ-014 FSM states SHALL be IDLE, SYNC, SEQ, LEN, PAYLOAD, CRC_LO, CRC_HI.
REQ-015 IDLE->SYNC SHALL occur when enable && samp_stream_avail && samp_stream_count != 0; LEN latched as min(samp_stream_count, MAX_PAYLOAD) in that same cycle.
REQ-016 A byte transfers only on a cycle with tx_valid && tx_ready; the state advances one step per transfer.
REQ-017 tx_valid SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-018 Once asserted, tx_valid and tx_data SHALL stay stable until transferred.
REQ-019 In PAYLOAD, tx_data SHALL equal samp_stream_data combinationally.
REQ-020 In PAYLOAD, samp_stream_pull SHALL equal tx_ready.
REQ-021 samp_stream_pull SHALL be 0 in every other state.
REQ-022 A remaining-byte counter SHALL load LEN and decrement per payload transfer.
REQ-023 The last payload transfer SHALL go to CRC_LO, or to IDLE if CRC is compiled out.
REQ-024 Packet completion (last byte transferred) SHALL increment SEQ (8-bit, 255->0) and pkt_count (16-bit, 0xFFFF->0) in the same cycle.
REQ-025 Latency: first SYNC byte is presented on tx_data the cycle after the IDLE trigger.
REQ-026 With tx_ready held high, back-to-back packets SHALL have exactly one IDLE cycle between them.
REQ-027 Deasserting enable mid-packet SHALL NOT truncate the packet; it only blocks the next IDLE->SYNC transition.
REQ-028 Upstream contract: samp_stream_count never decreases within a packet; the block does not re-check samp_stream_avail during PAYLOAD.
REQ-029 samp_stream_count > MAX_PAYLOAD SHALL yield LEN = MAX_PAYLOAD; the remainder goes in later packets.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, SEQ=0, pkt_count=0, remaining=0, CRC=0xFFFF.
REQ-031 rst_n low SHALL force tx_valid=0, samp_stream_pull=0, tx_data=0.
REQ-032 Reset mid-packet SHALL abandon the packet with no further bytes emitted; the next packet starts with SEQ=0.

Configuration
REQ-033 Macro SAMP_STREAM_READER_CRC_EN SHALL gate the CRC.
REQ-034 When SAMP_STREAM_READER_CRC_EN is defined:
- CRC-16/CCITT, polynomial 0x1021, init 0xFFFF, MSB-first, no final XOR.
- Covers the SEQ, LEN and payload bytes; reinitialised at SYNC.
- Emitted low byte then high byte.
REQ-035 When SAMP_STREAM_READER_CRC_EN is undefined, the CRC_LO and CRC_HI states and all CRC logic SHALL be absent and packets end after the payload.

Structure
REQ-036 Shared package sampq_pkg SHALL hold SYNC_BYTE (0x7E), the FSM state enum, CRC_POLY (0x1021), CRC_INIT (0xFFFF) and SAMPLE_BYTES (9).
REQ-037 One sub-module crc16_ccitt_byte (combinational: crc_in, byte -> crc_out) SHALL be instantiated only under SAMP_STREAM_READER_CRC_EN.

Verification
REQ-038 CRC on, count=18, tx_ready=1, SEQ=0, payload 0x01..0x12 -> bytes 7E 00 12 01..12 plus correct CRC; 18 pulls; pkt_count=1.
REQ-039 count=864 held, MAX_PAYLOAD=252 -> consecutive packets with LEN=0xFC, SEQ 0,1,2...; exactly 252 pulls each; one IDLE cycle between packets.
REQ-040 tx_ready toggling 1,0,0,1 during PAYLOAD -> pull asserts only on ready cycles; tx_data stable while stalled; no byte lost or duplicated.
REQ-041 enable dropped after the LEN byte of a 9-byte packet -> full packet completes; no new SYNC while enable=0 even with avail=1.
REQ-042 rst_n pulsed low mid-PAYLOAD -> tx_valid=0 asynchronously; next packet starts 7E 00; pkt_count=0.
REQ-043 256 one-sample packets -> SEQ wraps FF->00; pkt_count=256.
